// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the consumer owns en, the generator drives coordinates, video flags and markers.
// Every generator-driven signal is registered at the source, so consumers see them aligned on the same cycle.
interface vga_timing_gen_if;
  logic       en;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    input  en,
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );

  modport slave (
    output en,
    input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: DrawX/DrawY, blank, active-low hs/vs, line/frame pulses, and a frame counter.
// All outputs are registered with zero latency relative to the coordinates; en=0 holds the raster and suppresses the pulses.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  vga_timing_gen_if.master   vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HT_M1    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_M1    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HV       = 10'(H_VISIBLE);
  localparam logic [9:0] VV       = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_line_start;
  logic       r_frame_start;
  logic [7:0] r_frame_count;

  logic       w_x_last;
  logic       w_y_last;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_blank_nxt;
  logic       w_hs_nxt;
  logic       w_vs_nxt;

  assign w_x_last = (r_x == HT_M1);
  assign w_y_last = (r_y == VT_M1);

  always_comb begin
    w_x_nxt = w_x_last ? 10'd0 : r_x + 10'd1;
    w_y_nxt = r_y;
    if (w_x_last) begin
      w_y_nxt = w_y_last ? 10'd0 : r_y + 10'd1;
    end
  end

  // Flags decode the position being entered so they land on the same edge as the coordinates.
  always_comb begin
    w_blank_nxt = (w_x_nxt < HV) && (w_y_nxt < VV);
    w_hs_nxt    = !((w_x_nxt >= HS_START) && (w_x_nxt < HS_END));
    w_vs_nxt    = !((w_y_nxt >= VS_START) && (w_y_nxt < VS_END));
  end

  // Reset parks the raster on the last pixel so the first enabled edge opens frame (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= HT_M1;
      r_y           <= VT_M1;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= 8'd0;
    end else if (vga.en) begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_blank       <= w_blank_nxt;
      r_hs          <= w_hs_nxt;
      r_vs          <= w_vs_nxt;
      r_line_start  <= w_x_last;
      r_frame_start <= w_x_last && w_y_last;
      if (w_x_last && w_y_last) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign vga.DrawX       = r_x;
  assign vga.DrawY       = r_y;
  assign vga.blank       = r_blank;
  assign vga.hs          = r_hs;
  assign vga.vs          = r_vs;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;
  assign vga.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size and a tiny-raster instance share en/reset stimulus and are scored against an arithmetic model.
module tb_vga_timing_gen;
  typedef logic [32:0] obs_t;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if ifa();
  vga_timing_gen_if ifb();

  vga_timing_gen u_a (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (ifa)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_VISIBLE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_b (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (ifb)
  );

  obs_t got_a, got_b;
  assign got_a = {ifa.DrawX, ifa.DrawY, ifa.blank, ifa.hs, ifa.vs,
                  ifa.line_start, ifa.frame_start, ifa.frame_count};
  assign got_b = {ifb.DrawX, ifb.DrawY, ifb.blank, ifb.hs, ifb.vs,
                  ifb.line_start, ifb.frame_start, ifb.frame_count};

  obs_t q_a[$];
  obs_t q_b[$];
  int   errors = 0;
  int   checks = 0;

  // n = enabled edges since reset; reset itself sits at linear index total-1.
  function automatic obs_t model(longint n, bit adv, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    longint ht, vt, tot, idx, fc;
    int x, y;
    bit blank, hs, vs, ls, fs;
    ht    = hv + hf + hsw + hb;
    vt    = vv + vf + vsw + vb;
    tot   = ht * vt;
    idx   = (n == 0) ? tot - 1 : (n - 1) % tot;
    x     = int'(idx % ht);
    y     = int'(idx / ht);
    fc    = ((n + tot - 1) / tot) % 256;
    blank = (x < hv) && (y < vv);
    hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
    vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
    ls    = adv && (x == 0);
    fs    = adv && (idx == 0);
    return {10'(x), 10'(y), blank, hs, vs, ls, fs, 8'(fc)};
  endfunction

  // Monitor: compare whatever the driver predicted for the edge just taken.
  initial begin
    obs_t exp_v;
    forever begin
      @(posedge vga_clk);
      #1;
      if (q_a.size() > 0) begin
        exp_v = q_a.pop_front();
        checks++;
        if (got_a !== exp_v) begin
          errors++;
          $display("FAIL dut_a_raster t=%0t got=%h want=%h", $time, got_a, exp_v);
        end
      end
      if (q_b.size() > 0) begin
        exp_v = q_b.pop_front();
        checks++;
        if (got_b !== exp_v) begin
          errors++;
          $display("FAIL dut_b_raster t=%0t got=%h want=%h", $time, got_b, exp_v);
        end
      end
    end
  end

  // Driver: choose reset/en for the coming edge and push the predicted state.
  initial begin
    longint n = 0;
    bit     adv;
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    for (int cyc = 0; cyc < 25000; cyc++) begin
      @(negedge vga_clk);
      reset_n = !(cyc < 3 || cyc == 3000 || cyc == 3001);
      if (cyc < 2000 || (cyc >= 3002 && cyc < 8000)) begin
        ifa.en = 1'b1;
      end else begin
        ifa.en = 1'($urandom_range(0, 1));
      end
      ifb.en = ifa.en;
      adv = 1'b0;
      if (!reset_n) begin
        n = 0;
      end else if (ifa.en) begin
        n++;
        adv = 1'b1;
      end
      q_a.push_back(model(n, adv, 640, 16, 96, 48, 480, 10, 2, 33));
      q_b.push_back(model(n, adv, 4, 1, 1, 1, 2, 1, 1, 1));
    end
    @(negedge vga_clk);
    repeat (2) @(posedge vga_clk);
    #2;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending_a=%0d pending_b=%0d want=0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
